// File: rtl/sync_cmd_decoder_if.sv
// ----------------------------------------------------------------------------
// sync_cmd_decoder_if
//   Bundles the byte stream, register-file and transmitter signals of the
//   command decoder.
//
//   master : the surrounding system (synchroniser, register file, transmitter)
//   slave  : the command decoder
//
//   Byte stream   : enable_pulse, sync_bus                      (master -> slave)
//   Register file : wr_en, rd_en, address, wr_data              (slave -> master)
//                   rd_data, rd_data_valid                      (master -> slave)
//   Transmitter   : tx_p_data, tx_d_valid                       (slave -> master)
//                   tx_busy                                     (master -> slave)
//   Status        : busy, err_cmd, frame_drop, err_timeout      (slave -> master)
// ----------------------------------------------------------------------------
interface sync_cmd_decoder_if #(
  parameter int BUS_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  enable_pulse;
  logic [BUS_WIDTH-1:0]  sync_bus;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]  wr_data;
  logic [BUS_WIDTH-1:0]  rd_data;
  logic                  rd_data_valid;
  logic [BUS_WIDTH-1:0]  tx_p_data;
  logic                  tx_d_valid;
  logic                  tx_busy;
  logic                  busy;
  logic                  err_cmd;
  logic                  frame_drop;
  logic                  err_timeout;

  modport master (
    output enable_pulse, sync_bus, rd_data, rd_data_valid, tx_busy,
    input  wr_en, rd_en, address, wr_data, tx_p_data, tx_d_valid,
           busy, err_cmd, frame_drop, err_timeout
  );

  modport slave (
    input  enable_pulse, sync_bus, rd_data, rd_data_valid, tx_busy,
    output wr_en, rd_en, address, wr_data, tx_p_data, tx_d_valid,
           busy, err_cmd, frame_drop, err_timeout
  );
endinterface

// File: rtl/sync_cmd_decoder.sv
// ----------------------------------------------------------------------------
// sync_cmd_decoder
//   Assembles command frames from the synchronised byte stream and executes
//   them against a register file:
//     write frame : WR_CMD, ADDR, DATA  -> one-cycle wr_en
//     read  frame : RD_CMD, ADDR        -> one-cycle rd_en, read data is then
//                                          handed to the transmitter on a
//                                          valid/busy handshake
//   Every output is a flop. Bytes arriving while a read is outstanding are
//   discarded and flagged on frame_drop; unknown opcodes flag err_cmd.
//
// Ports
//   clk    : destination-domain clock
//   rst_n  : asynchronous active-low reset
//   bus    : sync_cmd_decoder_if.slave (byte stream, register file, TX, status)
//
// Build option
//   CMD_TIMEOUT_EN : when defined, a partial frame left idle for TIMEOUT_CYCLES
//                    cycles is aborted and err_timeout pulses. Without it the
//                    TIMEOUT_CYCLES parameter does not exist and err_timeout
//                    is held at 0.
// ----------------------------------------------------------------------------
module sync_cmd_decoder #(
  parameter int                   BUS_WIDTH  = 8,
  parameter int                   ADDR_WIDTH = 4,
  parameter logic [BUS_WIDTH-1:0] WR_CMD     = 8'hAA,
  parameter logic [BUS_WIDTH-1:0] RD_CMD     = 8'hBB
`ifdef CMD_TIMEOUT_EN
  , parameter int                 TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  sync_cmd_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_TX_HOLD
  } state_e;

  state_e                state_q;
  logic                  wr_en_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] address_q;
  logic [BUS_WIDTH-1:0]  wr_data_q;
  logic [BUS_WIDTH-1:0]  tx_p_data_q;
  logic                  tx_d_valid_q;
  logic                  busy_q;
  logic                  err_cmd_q;
  logic                  frame_drop_q;
  logic                  err_timeout_q;

`ifdef CMD_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  // The abort fires on the edge that closes the TIMEOUT_CYCLES-th idle cycle.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]             idle_cnt_q;
`endif

  wire                  pulse = bus.enable_pulse;
  wire [BUS_WIDTH-1:0]  byte_in = bus.sync_bus;

  // NOTE: sequential state is assigned with <= only, so every flop in this
  // block samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      address_q     <= '0;
      wr_data_q     <= '0;
      tx_p_data_q   <= '0;
      tx_d_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      err_cmd_q     <= 1'b0;
      frame_drop_q  <= 1'b0;
      err_timeout_q <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      idle_cnt_q    <= '0;
`endif
    end else begin
      // NOTE: one-cycle strobes are cleared first and only set by the branch
      // that fires, so none of them can stick high for a second cycle.
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      err_cmd_q     <= 1'b0;
      frame_drop_q  <= 1'b0;
      err_timeout_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (pulse) begin
            if (byte_in == WR_CMD) begin
              state_q <= S_WR_ADDR;
              busy_q  <= 1'b1;
            end else if (byte_in == RD_CMD) begin
              state_q <= S_RD_ADDR;
              busy_q  <= 1'b1;
            end else begin
              err_cmd_q <= 1'b1;
            end
          end
        end

        S_WR_ADDR: begin
          if (pulse) begin
            address_q <= byte_in[ADDR_WIDTH-1:0];
            state_q   <= S_WR_DATA;
          end
        end

        S_WR_DATA: begin
          if (pulse) begin
            wr_data_q <= byte_in;
            wr_en_q   <= 1'b1;
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
          end
        end

        S_RD_ADDR: begin
          if (pulse) begin
            address_q <= byte_in[ADDR_WIDTH-1:0];
            rd_en_q   <= 1'b1;
            state_q   <= S_RD_WAIT;
          end
        end

        // Read data may arrive in the same cycle as rd_en; a byte arriving
        // here is dropped but does not block the read data capture.
        S_RD_WAIT: begin
          frame_drop_q <= pulse;
          if (bus.rd_data_valid) begin
            tx_p_data_q  <= bus.rd_data;
            tx_d_valid_q <= 1'b1;
            state_q      <= S_TX_HOLD;
          end
        end

        // tx_p_data_q is not touched here, so it stays stable while held.
        S_TX_HOLD: begin
          frame_drop_q <= pulse;
          if (!bus.tx_busy) begin
            tx_d_valid_q <= 1'b0;
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

`ifdef CMD_TIMEOUT_EN
      // Counts idle cycles of a partial frame; an arriving byte always wins
      // over an expiring count because the case above already accepted it.
      if ((state_q inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR}) && !pulse) begin
        if (idle_cnt_q == CNT_LAST) begin
          idle_cnt_q    <= '0;
          state_q       <= S_IDLE;
          busy_q        <= 1'b0;
          err_timeout_q <= 1'b1;
        end else begin
          idle_cnt_q <= idle_cnt_q + 1'b1;
        end
      end else begin
        idle_cnt_q <= '0;
      end
`endif
    end
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.address     = address_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.tx_p_data   = tx_p_data_q;
  assign bus.tx_d_valid  = tx_d_valid_q;
  assign bus.busy        = busy_q;
  assign bus.err_cmd     = err_cmd_q;
  assign bus.frame_drop  = frame_drop_q;
  assign bus.err_timeout = err_timeout_q;

endmodule
